// File: rtl/cam_frame_gen.sv
// cam_frame_gen: OV7670-style RGB565 test-pattern source (vsync/href/px_data, high byte first).
// Build with CAM_FRAME_COUNT_EN to add frame_cnt and make the ramp pattern scroll each frame.
module cam_frame_gen #(
  parameter int H_ACTIVE    = 176,
  parameter int V_ACTIVE    = 140,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  pattern,
  input  logic [15:0] color,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  px_data,
  output logic        frame_done,
  output logic        busy
`ifdef CAM_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int LINE_LEN = 2*H_ACTIVE + H_BLANK;
  localparam int MAX_VL   = (VSYNC_LINES > V_BACK) ?
                            ((VSYNC_LINES > V_FRONT) ? VSYNC_LINES : V_FRONT) :
                            ((V_BACK > V_FRONT) ? V_BACK : V_FRONT);
  localparam int CW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int LW = (MAX_VL > 1)   ? $clog2(MAX_VL)   : 1;
  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  localparam logic [CW-1:0] CYC_LAST = CW'(LINE_LEN - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(2*H_ACTIVE - 1);
  localparam logic [LW-1:0] VS_LAST  = LW'(VSYNC_LINES - 1);
  localparam logic [LW-1:0] VB_LAST  = LW'(V_BACK - 1);
  localparam logic [LW-1:0] VF_LAST  = LW'(V_FRONT - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
  localparam logic [31:0]   BAR_W    = (H_ACTIVE >= 8) ? 32'(H_ACTIVE / 8) : 32'd1;

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ROW, S_HBLANK, S_VFRONT} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cyc, cyc_n;
  logic [LW-1:0]  line_cnt, line_n;
  logic [XW-1:0]  x, x_n;
  logic [YW-1:0]  y, y_n;
  logic           phase, phase_n;
  logic [1:0]     pat_q, pat_n;
  logic [15:0]    col_q, col_n;
  logic           cyc_last;
  logic [15:0]    pix;
  logic [4:0]     x5, rx;
  logic [5:0]     y6;
  logic [31:0]    bar_i;

  always_comb begin
    state_n  = state;
    cyc_n    = cyc;
    line_n   = line_cnt;
    x_n      = x;
    y_n      = y;
    phase_n  = phase;
    pat_n    = pat_q;
    col_n    = col_q;
    cyc_last = (cyc == CYC_LAST);
    case (state)
      S_IDLE: begin
        if (en) begin
          state_n = S_VSYNC;
          pat_n   = pattern;
          col_n   = color;
          cyc_n   = '0;
          line_n  = '0;
        end
      end
      S_VSYNC, S_VBACK, S_VFRONT: begin
        cyc_n = cyc_last ? '0 : cyc + 1'b1;
        if (cyc_last) begin
          line_n = line_cnt + 1'b1;
          if (state == S_VSYNC && line_cnt == VS_LAST) begin
            state_n = S_VBACK;
            line_n  = '0;
          end else if (state == S_VBACK && line_cnt == VB_LAST) begin
            state_n = S_ROW;
            line_n  = '0;
            x_n     = '0;
            y_n     = '0;
            phase_n = 1'b0;
          end else if (state == S_VFRONT && line_cnt == VF_LAST) begin
            // en is only honoured here and in IDLE, so a mid-frame drop lets the frame finish
            line_n = '0;
            if (en) begin
              state_n = S_VSYNC;
              pat_n   = pattern;
              col_n   = color;
            end else begin
              state_n = S_IDLE;
            end
          end
        end
      end
      S_ROW: begin
        cyc_n   = cyc + 1'b1;
        phase_n = ~phase;
        if (phase)
          x_n = x + 1'b1;
        if (cyc == ROW_LAST) begin
          state_n = S_HBLANK;
          x_n     = '0;
          phase_n = 1'b0;
        end
      end
      S_HBLANK: begin
        cyc_n = cyc_last ? '0 : cyc + 1'b1;
        if (cyc_last) begin
          if (y == Y_LAST) begin
            state_n = S_VFRONT;
            line_n  = '0;
            y_n     = '0;
          end else begin
            state_n = S_ROW;
            y_n     = y + 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Pixel is evaluated on the next-cycle coordinates so the byte can be registered.
  always_comb begin
    x5    = 5'(x_n);
    y6    = 6'(y_n);
    bar_i = 32'(x_n) / BAR_W;
`ifdef CAM_FRAME_COUNT_EN
    rx = x5 + frame_cnt[4:0];
`else
    rx = x5;
`endif
    pix = col_n;
    case (pat_n)
      2'd0: pix = col_n;
      2'd1: begin
        if (bar_i > 32'd7) pix = 16'h0000;
        else begin
          case (bar_i[2:0])
            3'd0:    pix = 16'hFFFF;
            3'd1:    pix = 16'hFFE0;
            3'd2:    pix = 16'h07FF;
            3'd3:    pix = 16'h07E0;
            3'd4:    pix = 16'hF81F;
            3'd5:    pix = 16'hF800;
            3'd6:    pix = 16'h001F;
            default: pix = 16'h0000;
          endcase
        end
      end
      2'd2:    pix = {rx, y6, x5};
      default: pix = (x5[3] ^ y6[3]) ? ~col_n : col_n;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state      <= S_IDLE;
      cyc        <= '0;
      line_cnt   <= '0;
      x          <= '0;
      y          <= '0;
      phase      <= 1'b0;
      pat_q      <= '0;
      col_q      <= '0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      px_data    <= 8'h00;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cyc        <= cyc_n;
      line_cnt   <= line_n;
      x          <= x_n;
      y          <= y_n;
      phase      <= phase_n;
      pat_q      <= pat_n;
      col_q      <= col_n;
      vsync      <= (state_n == S_VSYNC);
      href       <= (state_n == S_ROW);
      px_data    <= (state_n == S_ROW) ? (phase_n ? pix[7:0] : pix[15:8]) : 8'h00;
      frame_done <= (state_n == S_VFRONT) && (line_n == VF_LAST) && (cyc_n == CYC_LAST);
      busy       <= (state_n != S_IDLE);
    end
  end

`ifdef CAM_FRAME_COUNT_EN
  always_ff @(posedge pclk) begin
    if (rst)
      frame_cnt <= 16'h0000;
    else if (frame_done)
      frame_cnt <= frame_cnt + 16'h0001;
  end
`endif

endmodule
